// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// Takes both register-file operands and a destination index. It computes one
// M-extension op (selected by funct3) over a fixed XLEN+1 cycle latency and
// returns result + rd for write-back.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               request; accepted only in IDLE or DONE
//   op[2:0]             funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   rs1_data, rs2_data  operands A and B
//   rd_in[4:0]          destination index, carried through
//   abort               flush the in-flight operation
//   busy                high while in RUN or FIX
//   done                one-cycle pulse; result/rd_out valid
//   result, rd_out      final value and destination, held until next done
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   sum_mul;
  logic [XLEN:0]   r_sh, diff;
  logic            use_sub;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem;

  always_comb begin
    // Operand signedness from funct3 of the incoming request.
    a_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg    = a_signed & rs1_data[XLEN-1];
    b_neg    = b_signed & rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;

    // Shift-add multiply: {hi,lo} holds partial product and remaining multiplier.
    sum_mul  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring divide: hi = partial remainder, lo = dividend shifting into quotient.
    // A set top bit of r_sh means the subtraction always succeeds.
    r_sh     = {hi_q, lo_q[XLEN-1]};
    diff     = r_sh - {1'b0, opnd_q};
    use_sub  = r_sh[XLEN] | ~diff[XLEN];

    prod     = {hi_q, lo_q};
    prod_s   = neg_res_q ? -prod : prod;
    quo      = neg_res_q ? -lo_q : lo_q;
    rem      = neg_rem_q ? -hi_q : hi_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d   = RUN;
          cnt_d     = '0;
          hi_d      = '0;
          lo_d      = op[2] ? a_mag : b_mag;
          opnd_d    = op[2] ? b_mag : a_mag;
          op_d      = op;
          rd_d      = rd_in;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (rs2_data == '0);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            hi_d = use_sub ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], use_sub};
          end else begin
            hi_d = sum_mul[XLEN:1];
            lo_d = {sum_mul[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      default: begin // FIX
        if (abort) begin
          state_d = IDLE;
        end else begin
          case (op_q)
            3'd0:       result_d = prod_s[XLEN-1:0];
            3'd4, 3'd5: result_d = dz_q ? '1 : quo;
            3'd6, 3'd7: result_d = rem;
            default:    result_d = prod_s[2*XLEN-1:XLEN];
          endcase
          rd_out_d = rd_q;
          state_d  = DONE;
        end
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- scoreboard bench for muldiv_unit: expected results come from
// a 64-bit arithmetic reference model and are checked by an independent monitor.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        abort;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .abort(abort),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        check("latency", cyc, e.due);
        last_res = e.res;
        last_rd  = e.rd;
      end
    end
  end

  task automatic wait_idle();
    int unsigned w = 0;
    while (busy && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit push);
    exp_t e;
    wait_idle();
    op = f; rs1_data = a; rs2_data = b; rd_in = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    if (push) begin
      e.res = ref_model(f, a, b);
      e.rd  = r;
      e.due = cyc + 33;
      sb_q.push_back(e);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;
    int unsigned w;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);

    // Directed corner cases, issued back-to-back.
    issue(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 1'b1);
    issue(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6, 1'b1);
    issue(3'd5, 32'd100,        32'd0,         5'd7, 1'b1);
    issue(3'd7, 32'd100,        32'd0,         5'd8, 1'b1);
    issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd5, 1'b1);
    issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9, 1'b1);
    issue(3'd4, 32'hFFFF_FF00,  32'd0,         5'd10, 1'b1);
    issue(3'd6, 32'hFFFF_FF00,  32'd0,         5'd0, 1'b1);

    // Abort at RUN cycle 10: no done, outputs held.
    wait_idle();
    @(posedge clk); #1;
    issue(3'd0, 32'd3, 32'd4, 5'd11, 1'b0);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, last_res);
    check("abort_rd", {27'd0, rd_out}, {27'd0, last_rd});
    repeat (40) @(posedge clk);
    #1;

    // Start while busy is ignored.
    issue(3'd5, 32'd1000, 32'd7, 5'd12, 1'b1);
    repeat (5) @(posedge clk);
    #1 op = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd13; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;

    // Reset at RUN cycle 20 clears everything.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd", {27'd0, rd_out}, 32'd0);
    last_res = '0; last_rd = '0;

    // Start held high through DONE: a second op follows immediately.
    op = 3'd0; rs1_data = 32'd123; rs2_data = 32'hFFFF_FF85; rd_in = 5'd15; start = 1'b1;
    @(posedge clk); #1;
    e.res = ref_model(3'd0, 32'd123, 32'hFFFF_FF85);
    e.rd  = 5'd15;
    e.due = cyc + 33;
    sb_q.push_back(e);
    e.due = cyc + 33 + 34;
    sb_q.push_back(e);
    repeat (34) @(posedge clk);
    #1 start = 1'b0;

    // Randomised operations.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      issue(f, pick_operand(), pick_operand(), 5'($urandom), 1'b1);
    end

    w = 0;
    while (sb_q.size() != 0 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("scoreboard_empty", sb_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
